// File: rtl/apb_pkg.sv
// Shared APB definitions for the modport_slave register bank and its bench.
//   DUT_START_ADDRESS / DUT_END_ADDRESS : byte window the master selects the slave for.
//   APB_MAX_WAIT_STATES                 : largest legal wait-state setting.
//   APB_INPUT_DELAY                     : drive skew after the clock edge used by masters.
//   apb_state_t                         : transfer phase encoding (IDLE / SETUP / ACCESS).
package apb_pkg;

   localparam logic [31:0] DUT_START_ADDRESS   = 32'h8C00_0000;
   localparam logic [31:0] DUT_END_ADDRESS     = 32'h8C00_003F;
   localparam int unsigned APB_MAX_WAIT_STATES = 15;
   localparam int unsigned APB_INPUT_DELAY     = 1;

   // Wait counter width, wide enough to hold APB_MAX_WAIT_STATES.
   localparam int unsigned APB_CNT_W = $clog2(APB_MAX_WAIT_STATES + 1);

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess
   } apb_state_t;

   // True when a byte address is word aligned.
   function automatic logic apb_is_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB transfer sequencer: tracks the bus phase and inserts a fixed number of wait states.
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   psel_i         slave select
//   penable_i      access phase strobe
//   pready_o       transfer complete (1 outside a live access phase)
//   access_done_o  1 in the single cycle a legal access phase completes
module apb_wait_ctrl
   import apb_pkg::*;
#(
   parameter int unsigned WaitStates = 0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic psel_i,
   input  logic penable_i,
   output logic pready_o,
   output logic access_done_o
);

   localparam logic [APB_CNT_W-1:0] WaitCnt = APB_CNT_W'(WaitStates);

   // state_q holds the phase of the previous cycle; phase is the phase of this cycle.
   apb_state_t               state_q, state_d;
   apb_state_t               phase;
   logic [APB_CNT_W-1:0]     cnt_q, cnt_d;

   // Current-phase decode. An access phase is only legal straight after a setup phase
   // or a stalled access; penable arriving from idle is a protocol violation and is
   // treated as idle (default-ready, no side effects).
   always_comb begin
      phase = StIdle;
      if (rst_i) begin
         phase = StIdle;
      end else if (psel_i && !penable_i) begin
         phase = StSetup;
      end else if (psel_i && penable_i && (state_q == StSetup || state_q == StAccess)) begin
         phase = StAccess;
      end
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. The counter stays cleared outside a stalled access, so it reads
   // zero in the first access cycle and counts stalled cycles from there.
   always_comb begin
      state_d = StIdle;
      cnt_d   = '0;
      unique case (phase)
         StSetup: begin
            state_d = StSetup;
         end
         StAccess: begin
            if (!pready_o) begin
               state_d = StAccess;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs.
   always_comb begin
      pready_o      = 1'b1;
      access_done_o = 1'b0;
      if (phase == StAccess) begin
         pready_o      = (cnt_q == WaitCnt);
         access_done_o = (cnt_q == WaitCnt);
      end
   end

endmodule

// File: rtl/modport_slave.sv
// APB (AMBA3) slave register bank, word addressed, 32-bit data.
// Register 0 is a read-only ID word; registers 1..NUM_REGS-1 are read/write.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   psel     slave select
//   penable  access phase
//   pwrite   1 = write, 0 = read
//   paddr    byte address
//   pwdata   write data
//   prdata   read data (0 unless a clean read is on the bus)
//   pready   transfer complete
//   pslverr  transfer error, only asserted together with pready
module modport_slave
   import apb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DUT_START_ADDRESS,
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'hA0B0_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr
);

   localparam int unsigned IdxW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [31:0] SpanBytes = 32'(4 * NUM_REGS);

   if (WAIT_STATES > APB_MAX_WAIT_STATES) begin : g_bad_wait_states
      $error("modport_slave: WAIT_STATES exceeds APB_MAX_WAIT_STATES");
   end
   if (NUM_REGS < 2) begin : g_bad_num_regs
      $error("modport_slave: NUM_REGS must be at least 2");
   end

   logic [31:0]      offset;
   logic [IdxW-1:0]  idx;
   logic             misaligned;
   logic             out_of_range;
   logic             id_write;
   logic             error;
   logic             access_done;
   logic             wr_commit;
   logic             rd_active;
   logic [31:0]      rd_word;
   logic [31:0]      regs_q [1:NUM_REGS-1];

   apb_wait_ctrl #(
      .WaitStates (WAIT_STATES)
   ) u_wait_ctrl (
      .clk_i         (clk),
      .rst_i         (rst),
      .psel_i        (psel),
      .penable_i     (penable),
      .pready_o      (pready),
      .access_done_o (access_done)
   );

   // Address decode. The unsigned subtraction wraps addresses below BASE_ADDR to huge
   // offsets, so a single compare catches both ends of the window.
   always_comb begin
      offset       = paddr - BASE_ADDR;
      idx          = offset[IdxW+1:2];
      misaligned   = !apb_is_aligned(paddr);
      out_of_range = (offset >= SpanBytes);
      id_write     = pwrite && (idx == '0);
      error        = misaligned || out_of_range || id_write;
   end

   assign wr_commit = access_done && pwrite && !error;
   assign rd_active = !rst && psel && penable && !pwrite && !error;
   assign pslverr   = error && access_done;

   // Register array; reset takes priority so a reset cycle never commits a write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_commit) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (idx == IdxW'(i)) begin
               regs_q[i] <= pwdata;
            end
         end
      end
   end

   // Read mux.
   always_comb begin
      rd_word = '0;
      if (idx == '0) begin
         rd_word = ID_VALUE;
      end
      for (int i = 1; i < NUM_REGS; i++) begin
         if (idx == IdxW'(i)) begin
            rd_word = regs_q[i];
         end
      end
   end

   assign prdata = rd_active ? rd_word : '0;

endmodule

// File: tb/tb_modport_slave.sv
module tb_modport_slave;
   import apb_pkg::*;

   localparam logic [31:0] Id       = 32'hA0B0_0001;
   localparam int          SlowWait = 3;

   logic        clk;
   logic        rst;
   logic        psel0, penable0, pwrite0, pready0, pslverr0;
   logic [31:0] paddr0, pwdata0, prdata0;
   logic        psel1, penable1, pwrite1, pready1, pslverr1;
   logic [31:0] paddr1, pwdata1, prdata1;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference contents per DUT (0 = no wait states, 1 = SlowWait wait states).
   logic [31:0] model [2][16];

   modport_slave #(
      .WAIT_STATES (0)
   ) u_dut_fast (
      .clk     (clk),
      .rst     (rst),
      .psel    (psel0),
      .penable (penable0),
      .pwrite  (pwrite0),
      .paddr   (paddr0),
      .pwdata  (pwdata0),
      .prdata  (prdata0),
      .pready  (pready0),
      .pslverr (pslverr0)
   );

   modport_slave #(
      .WAIT_STATES (SlowWait)
   ) u_dut_slow (
      .clk     (clk),
      .rst     (rst),
      .psel    (psel1),
      .penable (penable1),
      .pwrite  (pwrite1),
      .paddr   (paddr1),
      .pwdata  (pwdata1),
      .prdata  (prdata1),
      .pready  (pready1),
      .pslverr (pslverr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_bus(input int d, input logic s, input logic e, input logic w,
                          input logic [31:0] a, input logic [31:0] wd);
      if (d == 0) begin
         psel0 = s; penable0 = e; pwrite0 = w; paddr0 = a; pwdata0 = wd;
      end else begin
         psel1 = s; penable1 = e; pwrite1 = w; paddr1 = a; pwdata1 = wd;
      end
   endtask

   function automatic logic get_pready(input int d);
      return (d == 0) ? pready0 : pready1;
   endfunction

   function automatic logic get_pslverr(input int d);
      return (d == 0) ? pslverr0 : pslverr1;
   endfunction

   function automatic logic [31:0] get_prdata(input int d);
      return (d == 0) ? prdata0 : prdata1;
   endfunction

   function automatic bit exp_err(input bit wr, input logic [31:0] a);
      bit bad;
      bad = (a < DUT_START_ADDRESS) || (a > DUT_END_ADDRESS) || (a % 4 != 0);
      if (!bad && wr && ((a - DUT_START_ADDRESS) / 4 == 0)) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [31:0] exp_read(input int d, input logic [31:0] a);
      int w;
      if (exp_err(1'b0, a)) return 32'h0;
      w = int'((a - DUT_START_ADDRESS) / 4);
      return (w == 0) ? Id : model[d][w];
   endfunction

   task automatic clear_models();
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < 16; w++) model[d][w] = 32'h0;
      end
   endtask

   // One complete APB transfer; reports data/error seen with pready and stalled cycles.
   task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int waits);
      bit done;
      done  = 1'b0;
      waits = 0;
      rdata = 32'h0;
      err   = 1'b0;
      @(posedge clk); #(APB_INPUT_DELAY);
      set_bus(d, 1'b1, 1'b0, wr, addr, wdata);
      @(posedge clk); #(APB_INPUT_DELAY);
      set_bus(d, 1'b1, 1'b1, wr, addr, wdata);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (get_pready(d) === 1'b1) begin
            rdata = get_prdata(d);
            err   = get_pslverr(d);
            done  = 1'b1;
         end else begin
            waits++;
         end
      end
      @(posedge clk); #(APB_INPUT_DELAY);
      set_bus(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL xfer_timeout: dut %0d addr %h got no pready want pready within 40", d,
                  addr);
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        er;
      int          wt;
      rst = 1'b1;
      set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      clear_models();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (pready0 !== 1'b1 || pready1 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pready: got %b/%b want 1/1", pready0, pready1);
      end
      n_cmp++;
      if (pslverr0 !== 1'b0 || pslverr1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pslverr: got %b/%b want 0/0", pslverr0, pslverr1);
      end
      n_cmp++;
      if (prdata0 !== 32'h0 || prdata1 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_prdata: got %h/%h want 0/0", prdata0, prdata1);
      end
      @(posedge clk); #(APB_INPUT_DELAY);
      rst = 1'b0;
      apb_xfer(0, 1'b0, 32'h8C00_0000, 32'h0, rd, er, wt);
      n_cmp++;
      if (rd !== Id || er !== 1'b0 || wt != 0) begin
         n_fail++;
         $display("FAIL reset_id_read: got %h err %b waits %0d want %h err 0 waits 0",
                  rd, er, wt, Id);
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd;
      logic        er;
      int          wt;
      apb_xfer(0, 1'b1, 32'h8C00_0004, 32'hDEAD_BEEF, rd, er, wt);
      model[0][1] = 32'hDEAD_BEEF;
      n_cmp++;
      if (er !== 1'b0) begin
         n_fail++;
         $display("FAIL write_err: got %b want 0", er);
      end
      apb_xfer(0, 1'b0, 32'h8C00_0004, 32'h0, rd, er, wt);
      n_cmp++;
      if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
         n_fail++;
         $display("FAIL readback: got %h err %b want deadbeef err 0", rd, er);
      end
      apb_xfer(0, 1'b0, 32'h8C00_0008, 32'h0, rd, er, wt);
      n_cmp++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL read_untouched: got %h err %b want 0 err 0", rd, er);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic        er;
      int          wt;
      apb_xfer(0, 1'b1, 32'h8C00_0000, 32'h1234_5678, rd, er, wt);
      n_cmp++;
      if (er !== 1'b1) begin
         n_fail++;
         $display("FAIL id_write_err: got %b want 1", er);
      end
      apb_xfer(0, 1'b0, 32'h8C00_0000, 32'h0, rd, er, wt);
      n_cmp++;
      if (rd !== Id || er !== 1'b0) begin
         n_fail++;
         $display("FAIL id_after_write: got %h err %b want %h err 0", rd, er, Id);
      end
      apb_xfer(0, 1'b0, 32'h8C00_0006, 32'h0, rd, er, wt);
      n_cmp++;
      if (rd !== 32'h0 || er !== 1'b1) begin
         n_fail++;
         $display("FAIL unaligned_read: got %h err %b want 0 err 1", rd, er);
      end
      apb_xfer(0, 1'b0, 32'h8C00_0040, 32'h0, rd, er, wt);
      n_cmp++;
      if (rd !== 32'h0 || er !== 1'b1) begin
         n_fail++;
         $display("FAIL above_range_read: got %h err %b want 0 err 1", rd, er);
      end
      apb_xfer(1, 1'b1, 32'h8BFF_FFFC, 32'hCAFE_F00D, rd, er, wt);
      n_cmp++;
      if (er !== 1'b1 || wt != SlowWait) begin
         n_fail++;
         $display("FAIL below_range_write: got err %b waits %0d want err 1 waits %0d",
                  er, wt, SlowWait);
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd;
      logic        er;
      int          wt;
      apb_xfer(1, 1'b1, 32'h8C00_003C, 32'h5A5A_5A5A, rd, er, wt);
      model[1][15] = 32'h5A5A_5A5A;
      n_cmp++;
      if (wt != SlowWait || er !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_write: got waits %0d err %b want waits %0d err 0", wt, er,
                  SlowWait);
      end
      apb_xfer(1, 1'b0, 32'h8C00_003C, 32'h0, rd, er, wt);
      n_cmp++;
      if (rd !== 32'h5A5A_5A5A || wt != SlowWait || er !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_readback: got %h waits %0d err %b want 5a5a5a5a waits %0d err 0",
                  rd, wt, er, SlowWait);
      end
   endtask

   task automatic test_protocol();
      logic [31:0] rd;
      logic        er;
      int          wt;
      // penable straight from idle: must be ignored.
      @(posedge clk); #(APB_INPUT_DELAY);
      set_bus(0, 1'b1, 1'b1, 1'b1, 32'h8C00_000C, 32'h1111_2222);
      @(negedge clk);
      n_cmp++;
      if (pready0 !== 1'b1 || pslverr0 !== 1'b0) begin
         n_fail++;
         $display("FAIL no_setup_outputs: got pready %b pslverr %b want 1 0", pready0, pslverr0);
      end
      @(posedge clk); #(APB_INPUT_DELAY);
      set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      apb_xfer(0, 1'b0, 32'h8C00_000C, 32'h0, rd, er, wt);
      n_cmp++;
      if (rd !== model[0][3]) begin
         n_fail++;
         $display("FAIL no_setup_nowrite: got %h want %h", rd, model[0][3]);
      end
      // psel dropped during a stalled access: aborted, nothing written.
      @(posedge clk); #(APB_INPUT_DELAY);
      set_bus(1, 1'b1, 1'b0, 1'b1, 32'h8C00_0020, 32'hABCD_ABCD);
      @(posedge clk); #(APB_INPUT_DELAY);
      set_bus(1, 1'b1, 1'b1, 1'b1, 32'h8C00_0020, 32'hABCD_ABCD);
      @(negedge clk);
      n_cmp++;
      if (pready1 !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_stall: got pready %b want 0", pready1);
      end
      @(posedge clk); #(APB_INPUT_DELAY);
      set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      apb_xfer(1, 1'b0, 32'h8C00_0020, 32'h0, rd, er, wt);
      n_cmp++;
      if (rd !== model[1][8]) begin
         n_fail++;
         $display("FAIL abort_nowrite: got %h want %h", rd, model[1][8]);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, addr, wd, exp;
      logic        er;
      int          wt, d, word;
      bit          wr, e;
      for (int i = 0; i < 80; i++) begin
         d    = int'($urandom_range(0, 1));
         wr   = 1'($urandom_range(0, 1));
         word = int'($urandom_range(0, 17));
         addr = DUT_START_ADDRESS + 32'(word * 4);
         if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0) addr = DUT_START_ADDRESS - 32'(4 * (word + 1));
         wd   = $urandom;
         e    = exp_err(wr, addr);
         exp  = exp_read(d, addr);
         apb_xfer(d, wr, addr, wd, rd, er, wt);
         if (wr && !e) model[d][(addr - DUT_START_ADDRESS) / 4] = wd;
         n_cmp++;
         if (er !== e || wt != ((d == 0) ? 0 : SlowWait)) begin
            n_fail++;
            $display("FAIL rand_status[%0d]: dut %0d addr %h got err %b waits %0d want err %b",
                     i, d, addr, er, wt, e);
         end
         if (!wr) begin
            n_cmp++;
            if (rd !== exp) begin
               n_fail++;
               $display("FAIL rand_rdata[%0d]: dut %0d addr %h got %h want %h", i, d, addr, rd,
                        exp);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic        er;
      int          wt;
      apb_xfer(0, 1'b1, 32'h8C00_0010, 32'hFFFF_FFFF, rd, er, wt);
      @(posedge clk); #(APB_INPUT_DELAY);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ($isunknown({pready0, pslverr0, pready1, pslverr1}) || pready0 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_outputs_known: got pready %b pslverr %b want 1 0", pready0,
                  pslverr0);
      end
      @(posedge clk); #(APB_INPUT_DELAY);
      rst = 1'b0;
      clear_models();
      apb_xfer(0, 1'b0, 32'h8C00_0010, 32'h0, rd, er, wt);
      n_cmp++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_clears: got %h err %b want 0 err 0", rd, er);
      end
      // Reset lands on the completing access cycle of a write.
      @(posedge clk); #(APB_INPUT_DELAY);
      set_bus(0, 1'b1, 1'b0, 1'b1, 32'h8C00_0014, 32'h7777_8888);
      @(posedge clk); #(APB_INPUT_DELAY);
      set_bus(0, 1'b1, 1'b1, 1'b1, 32'h8C00_0014, 32'h7777_8888);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (pslverr0 !== 1'b0 || pready0 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got pready %b pslverr %b want 1 0", pready0,
                  pslverr0);
      end
      @(posedge clk); #(APB_INPUT_DELAY);
      rst = 1'b0;
      set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      apb_xfer(0, 1'b0, 32'h8C00_0014, 32'h0, rd, er, wt);
      n_cmp++;
      if (rd !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_nowrite: got %h want 0", rd);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_errors();
      test_wait_states();
      test_protocol();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
